spi_fifo_ctrl: RTL

SPI_FIFO_CTRL -- requirements
Module: spi_fifo_ctrl

---
 rtl/spi_fifo_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/spi_fifo_ctrl.sv
// SPI front end: TX and RX word FIFOs around a single-transfer launch FSM.
// Control words (chip select, engine mode) are deferred to the next idle cycle.
module spi_fifo_ctrl #(
  parameter int DEPTH   = 8,
  parameter int CS_BITS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_data_en,
  input  logic [31:0]        wr_data,
  input  logic               rd_data_en,
  output logic [31:0]        rd_data,
  input  logic               wr_ctrl_en,
  input  logic [31:0]        wr_ctrl,
  output logic [31:0]        status,
  output logic               spi_start,
  output logic               spi_fast,
  output logic               spi_wordsize,
  output logic [31:0]        spi_dataTx,
  input  logic [31:0]        spi_dataRx,
  input  logic               spi_rdy,
  output logic [CS_BITS-1:0] cs_n
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_XFER   = 2'd2;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]     tx_cnt, rx_cnt;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_ovf;

  logic [1:0]        state;
  logic              discard;
  logic              pend;
  logic [3:0]        pend_cs;
  logic              pend_fast, pend_ws;

  logic              flush, launch, apply, rx_done;
  logic              tx_push, tx_drop, rx_push, rx_pop;
  logic              busy;
  logic              unused_ctrl_bits;

  function automatic logic [CS_BITS-1:0] decode_cs(input logic [3:0] sel);
    logic [CS_BITS-1:0] r;
    r = '1;
    for (int i = 0; i < CS_BITS; i++) begin
      if (sel == 4'(i + 1)) r[i] = 1'b0;
    end
    return r;
  endfunction

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign rx_empty = (rx_cnt == '0);

  assign flush   = wr_ctrl_en & wr_ctrl[31];
  assign launch  = (state == S_IDLE) & ~pend & ~tx_empty & ~rx_full;
  assign apply   = (state == S_IDLE) & pend;
  assign rx_done = (state == S_XFER) & spi_rdy;

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign tx_push = wr_data_en & (~tx_full | launch);
  assign tx_drop = wr_data_en & ~tx_push;
  assign rx_push = rx_done & ~discard;
  assign rx_pop  = rd_data_en & ~rx_empty;

  assign busy    = (state != S_IDLE) | ~tx_empty | pend;
  assign rd_data = rx_empty ? '0 : rx_mem[rx_rp];
  assign status  = {12'd0, tx_ovf, busy, rx_empty, tx_full, 8'(rx_cnt), 8'(tx_cnt)};

  assign unused_ctrl_bits = ^{wr_ctrl[30:10], wr_ctrl[7:4]};

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wr_data;
    if (rx_push) rx_mem[rx_wp] <= spi_dataRx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      tx_ovf <= 1'b0;
    end else if (flush) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (launch)  tx_rp <= tx_rp + AW'(1);
      if (tx_push && !launch)      tx_cnt <= tx_cnt + CW'(1);
      else if (!tx_push && launch) tx_cnt <= tx_cnt - CW'(1);
      if (tx_drop) tx_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else if (flush) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      spi_start  <= 1'b0;
      spi_dataTx <= '0;
      discard    <= 1'b0;
    end else begin
      spi_start <= launch;
      case (state)
        S_IDLE: begin
          if (launch) begin
            spi_dataTx <= tx_mem[tx_rp];
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: if (!spi_rdy) state <= S_XFER;
        S_XFER:   if (spi_rdy)  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
      if (rx_done) discard <= 1'b0;
      // A flush only orphans a transfer that is still running after this edge.
      if (flush && (launch || state == S_LAUNCH || (state == S_XFER && !spi_rdy)))
        discard <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ctrl_en) begin
      pend_cs   <= wr_ctrl[3:0];
      pend_fast <= wr_ctrl[8];
      pend_ws   <= wr_ctrl[9];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend         <= 1'b0;
      spi_fast     <= 1'b0;
      spi_wordsize <= 1'b0;
      cs_n         <= '1;
    end else begin
      if (apply) begin
        spi_fast     <= pend_fast;
        spi_wordsize <= pend_ws;
        cs_n         <= decode_cs(pend_cs);
        pend         <= 1'b0;
      end
      if (wr_ctrl_en) pend <= 1'b1;
    end
  end

endmodule
